// File: rtl/bisr_weight_load_ctrl.sv
// Load/compute sequencer for the BISR weight allocator: clears it, streams one tile of
// weight rows, waits on the recovery verdict, then sweeps read rows. Optional: BISR_LOAD_TIMEOUT_EN.
module bisr_weight_load_ctrl #(
  parameter int unsigned SYSTOLIC_SIZE  = 8,
  parameter int unsigned WEIGHT_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH     = $clog2(SYSTOLIC_SIZE)
`ifdef BISR_LOAD_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_cfg_start,
  input  logic                                   i_run_start,
  input  logic                                   i_src_valid,
  output logic                                   o_src_ready,
  input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0]  i_src_weights,
  output logic                                   o_alloc_weight_start,
  output logic                                   o_alloc_weight_valid,
  output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0]  o_alloc_weights,
  input  logic                                   i_alloc_recovery_done,
  input  logic                                   i_alloc_recovery_success,
  output logic [ADDR_WIDTH-1:0]                  o_rd_addr,
  output logic                                   o_rd_valid,
  output logic                                   o_busy,
  output logic                                   o_load_ok,
  output logic                                   o_load_fail,
  output logic                                   o_done
);

  localparam int unsigned LAST_ROW = SYSTOLIC_SIZE - 1;
`ifdef BISR_LOAD_TIMEOUT_EN
  localparam int unsigned CHK_W    = $clog2(TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD,
    ST_CHECK,
    ST_READY,
    ST_RUN
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_row_cnt;
  logic [ADDR_WIDTH-1:0] w_row_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr_nxt;
  logic                  r_load_ok;
  logic                  w_load_ok_nxt;
  logic                  r_load_fail;
  logic                  w_load_fail_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  r_src_ready;
  logic                  r_weight_start;
  logic                  r_rd_valid;
  logic                  r_busy;
  logic                  w_hs;
  logic                  w_chk_armed;
`ifdef BISR_LOAD_TIMEOUT_EN
  logic [CHK_W-1:0]      r_chk_cnt;
  logic [CHK_W-1:0]      w_chk_cnt_nxt;
`else
  logic                  r_chk_armed;
  logic                  w_chk_armed_nxt;
`endif

  assign w_hs = i_src_valid & r_src_ready;

  // Verdict inputs are only trusted from the second CHECK cycle on.
`ifdef BISR_LOAD_TIMEOUT_EN
  assign w_chk_armed = (r_chk_cnt != '0);
`else
  assign w_chk_armed = r_chk_armed;
`endif

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt     = r_state;
    w_row_cnt_nxt   = r_row_cnt;
    w_rd_addr_nxt   = r_rd_addr;
    w_load_ok_nxt   = r_load_ok;
    w_load_fail_nxt = r_load_fail;
    w_done_nxt      = 1'b0;
`ifdef BISR_LOAD_TIMEOUT_EN
    w_chk_cnt_nxt   = '0;
`else
    w_chk_armed_nxt = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (i_cfg_start) begin
          w_state_nxt     = ST_START;
          w_load_ok_nxt   = 1'b0;
          w_load_fail_nxt = 1'b0;
        end
      end
      ST_START: begin
        w_row_cnt_nxt = '0;
        w_state_nxt   = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_hs) begin
          w_row_cnt_nxt = r_row_cnt + ADDR_WIDTH'(1);
          if (r_row_cnt == ADDR_WIDTH'(LAST_ROW)) begin
            w_state_nxt = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
`ifdef BISR_LOAD_TIMEOUT_EN
        w_chk_cnt_nxt = r_chk_cnt + CHK_W'(1);
`else
        w_chk_armed_nxt = 1'b1;
`endif
        if (w_chk_armed && i_alloc_recovery_done) begin
          w_done_nxt = 1'b1;
          if (i_alloc_recovery_success) begin
            w_state_nxt   = ST_READY;
            w_load_ok_nxt = 1'b1;
          end else begin
            w_state_nxt     = ST_IDLE;
            w_load_fail_nxt = 1'b1;
          end
        end
`ifdef BISR_LOAD_TIMEOUT_EN
        else if (r_chk_cnt == CHK_W'(TIMEOUT_CYCLES - 1)) begin
          w_done_nxt      = 1'b1;
          w_state_nxt     = ST_IDLE;
          w_load_fail_nxt = 1'b1;
        end
`endif
      end
      ST_READY: begin
        if (i_cfg_start) begin
          w_state_nxt     = ST_START;
          w_load_ok_nxt   = 1'b0;
          w_load_fail_nxt = 1'b0;
        end else if (i_run_start) begin
          w_state_nxt   = ST_RUN;
          w_rd_addr_nxt = '0;
        end
      end
      ST_RUN: begin
        if (r_rd_addr == ADDR_WIDTH'(LAST_ROW)) begin
          w_state_nxt = ST_READY;
          w_done_nxt  = 1'b1;
        end else begin
          w_rd_addr_nxt = r_rd_addr + ADDR_WIDTH'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered state-decoded outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_row_cnt      <= '0;
      r_rd_addr      <= '0;
      r_load_ok      <= 1'b0;
      r_load_fail    <= 1'b0;
      r_done         <= 1'b0;
      r_src_ready    <= 1'b0;
      r_weight_start <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_busy         <= 1'b0;
`ifdef BISR_LOAD_TIMEOUT_EN
      r_chk_cnt      <= '0;
`else
      r_chk_armed    <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_nxt;
      r_row_cnt      <= w_row_cnt_nxt;
      r_rd_addr      <= w_rd_addr_nxt;
      r_load_ok      <= w_load_ok_nxt;
      r_load_fail    <= w_load_fail_nxt;
      r_done         <= w_done_nxt;
      r_src_ready    <= (w_state_nxt == ST_LOAD);
      r_weight_start <= (w_state_nxt == ST_START);
      r_rd_valid     <= (w_state_nxt == ST_RUN);
      r_busy         <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_READY);
`ifdef BISR_LOAD_TIMEOUT_EN
      r_chk_cnt      <= w_chk_cnt_nxt;
`else
      r_chk_armed    <= w_chk_armed_nxt;
`endif
    end
  end

  // Row payload and valid pass straight through to the allocator while loading.
  assign o_alloc_weight_valid = w_hs;
  assign o_alloc_weights      = r_src_ready ? i_src_weights : '0;

  assign o_src_ready          = r_src_ready;
  assign o_alloc_weight_start = r_weight_start;
  assign o_rd_addr            = r_rd_addr;
  assign o_rd_valid           = r_rd_valid;
  assign o_busy               = r_busy;
  assign o_load_ok            = r_load_ok;
  assign o_load_fail          = r_load_fail;
  assign o_done               = r_done;

endmodule

// File: tb/tb_bisr_weight_load_ctrl.sv
// Directed self-checking bench for bisr_weight_load_ctrl (S=8, 8-bit weights).
module tb_bisr_weight_load_ctrl;

  localparam int unsigned S  = 8;
  localparam int unsigned RW = 64;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start, run_start, src_valid, src_ready;
  logic [RW-1:0] src_weights, alloc_weights;
  logic          alloc_weight_start, alloc_weight_valid;
  logic          rec_done, rec_success;
  logic [AW-1:0] rd_addr;
  logic          rd_valid, busy, load_ok, load_fail, done;

  int n_tests = 0;
  int n_fail  = 0;

  bisr_weight_load_ctrl dut (
    .clk                      (clk),
    .rst                      (rst),
    .i_cfg_start              (cfg_start),
    .i_run_start              (run_start),
    .i_src_valid              (src_valid),
    .o_src_ready              (src_ready),
    .i_src_weights            (src_weights),
    .o_alloc_weight_start     (alloc_weight_start),
    .o_alloc_weight_valid     (alloc_weight_valid),
    .o_alloc_weights          (alloc_weights),
    .i_alloc_recovery_done    (rec_done),
    .i_alloc_recovery_success (rec_success),
    .o_rd_addr                (rd_addr),
    .o_rd_valid               (rd_valid),
    .o_busy                   (busy),
    .o_load_ok                (load_ok),
    .o_load_fail              (load_fail),
    .o_done                   (done)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rowv(input int i);
    return 64'h0123_4567_89AB_CDEF ^ {8{8'(i * 37 + 1)}};
  endfunction

  task automatic check_all_zero(input string tag);
    chk1({tag, "_src_ready"}, src_ready, 1'b0);
    chk1({tag, "_wstart"}, alloc_weight_start, 1'b0);
    chk1({tag, "_wvalid"}, alloc_weight_valid, 1'b0);
    chk64({tag, "_weights"}, alloc_weights, 64'h0);
    chk64({tag, "_rd_addr"}, 64'(rd_addr), 64'h0);
    chk1({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_load_ok"}, load_ok, 1'b0);
    chk1({tag, "_load_fail"}, load_fail, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
  endtask

  // cfg_start pulse; returns at the negedge of the first LOAD cycle.
  task automatic start_load();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
    chk1("start_pulse", alloc_weight_start, 1'b1);
    chk1("start_busy", busy, 1'b1);
    chk1("start_no_ready", src_ready, 1'b0);
    @(negedge clk);
  endtask

  // Feeds nrows rows (optionally with every other cycle idle); for a full tile,
  // also checks that CHECK is entered right after the last row.
  task automatic load_rows(input bit toggle, input int nrows);
    int  r = 0;
    int  c = 0;
    logic v;
    while (r < nrows && c < 64) begin
      v           = toggle ? logic'(c % 2 == 0) : 1'b1;
      src_valid   = v;
      src_weights = v ? rowv(r) : ~rowv(r);
      #1;
      chk1("load_src_ready", src_ready, 1'b1);
      chk1("load_wvalid", alloc_weight_valid, v);
      chk1("load_wstart_low", alloc_weight_start, 1'b0);
      if (v) begin
        chk64("load_row_data", alloc_weights, rowv(r));
        r++;
      end
      c++;
      if (r < nrows) @(negedge clk);
    end
    if (nrows == int'(S)) begin
      @(negedge clk);
      src_valid = 1'b1;
      #1;
      chk1("check_src_ready", src_ready, 1'b0);
      chk1("check_wvalid_gated", alloc_weight_valid, 1'b0);
      chk1("check_busy", busy, 1'b1);
      src_valid = 1'b0;
    end
  endtask

  // Entered at the first CHECK cycle; a verdict offered there must be ignored.
  task automatic verdict(input logic success);
    rec_done    = 1'b1;
    rec_success = success;
    @(negedge clk);
    #1;
    chk1("verdict_first_ignored", busy, 1'b1);
    chk1("verdict_ok_pending", load_ok, 1'b0);
    @(negedge clk);
    rec_done    = 1'b0;
    rec_success = 1'b0;
    #1;
    chk1("verdict_done", done, 1'b1);
    chk1("verdict_load_ok", load_ok, success);
    chk1("verdict_load_fail", load_fail, ~success);
    chk1("verdict_busy", busy, 1'b0);
    @(negedge clk);
    #1;
    chk1("verdict_done_pulse", done, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    cfg_start   = 1'b0;
    run_start   = 1'b0;
    src_valid   = 1'b0;
    src_weights = '0;
    rec_done    = 1'b0;
    rec_success = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Full load, source always valid, allocator reports success.
    start_load();
    load_rows(1'b0, S);
    verdict(1'b1);

    // Compute sweep; cfg_start mid-sweep must be ignored.
    run_start = 1'b1;
    @(negedge clk);
    run_start = 1'b0;
    for (int i = 0; i < int'(S); i++) begin
      cfg_start = (i == 3);
      #1;
      chk1("run_rd_valid", rd_valid, 1'b1);
      chk64("run_rd_addr", 64'(rd_addr), 64'(i));
      chk1("run_busy", busy, 1'b1);
      chk1("run_no_done", done, 1'b0);
      @(negedge clk);
    end
    cfg_start = 1'b0;
    #1;
    chk1("sweep_end_rd_valid", rd_valid, 1'b0);
    chk1("sweep_end_done", done, 1'b1);
    chk64("sweep_end_no_wrap", 64'(rd_addr), 64'(S - 1));
    chk1("sweep_end_busy", busy, 1'b0);
    chk1("sweep_end_load_ok", load_ok, 1'b1);
    @(negedge clk);

    // cfg_start and run_start together in READY: reload wins.
    cfg_start = 1'b1;
    run_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    run_start = 1'b0;
    #1;
    chk1("both_start_pulse", alloc_weight_start, 1'b1);
    chk1("both_no_run", rd_valid, 1'b0);
    chk1("both_ok_cleared", load_ok, 1'b0);
    @(negedge clk);

    // Gappy source, then a failed verdict; run_start afterwards does nothing.
    load_rows(1'b1, S);
    verdict(1'b0);
    run_start = 1'b1;
    @(negedge clk);
    run_start = 1'b0;
    #1;
    chk1("fail_run_rd_valid", rd_valid, 1'b0);
    chk1("fail_run_busy", busy, 1'b0);
    chk1("fail_sticky", load_fail, 1'b1);
    chk1("fail_ok_low", load_ok, 1'b0);
    @(negedge clk);

    // Async reset during row 4, then a clean reload.
    start_load();
    load_rows(1'b0, 4);
    @(negedge clk);
    src_valid   = 1'b1;
    src_weights = rowv(4);
    rst         = 1'b1;
    #1;
    check_all_zero("midload_rst");
    @(negedge clk);
    rst       = 1'b0;
    src_valid = 1'b0;
    @(negedge clk);
    start_load();
    load_rows(1'b0, S);
    verdict(1'b1);

`ifdef BISR_LOAD_TIMEOUT_EN
    // Allocator never answers: fail exactly 16 cycles into CHECK.
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    @(negedge clk);
    load_rows(1'b0, S);
    for (int k = 1; k <= 16; k++) begin
      chk1("to_wait_busy", busy, 1'b1);
      chk1("to_wait_no_fail", load_fail, 1'b0);
      @(negedge clk);
      #1;
    end
    chk1("to_fail", load_fail, 1'b1);
    chk1("to_done", done, 1'b1);
    chk1("to_busy", busy, 1'b0);
    chk1("to_ok_low", load_ok, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
